qspi_sram_responder: RTL and testbench

- Synthesizable QSPI SRAM responder (target side) for the QSPIShifter initiator.
- Sits on the other end of the cs_n/sio bus in the same clk domain. Decodes quad command, address and dummy phases, then accepts write data into, or returns read data from, an internal word memory.
- Serves as the bench memory model and as an FPGA loopback target.
- All phases are 4-bit (QPI). One nibble is transferred per clk posedge while cs_n is low; the MSB nibble goes first.

---
 rtl/qspi_pkg.sv | 26 ++
 rtl/qspi_sram_responder_if.sv | 27 ++
 rtl/qspi_nibble_shifter.sv | 50 +++++
 rtl/qspi_sram_responder.sv | 165 ++++++++++++++++
 tb/tb_qspi_sram_responder.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/qspi_pkg.sv
// Shared types and constants for the QSPI SRAM responder: FSM states,
// default opcodes and phase lengths in nibbles.
package qspi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        DUMMY,
        WDATA,
        RDATA,
        DISCARD
    } state_e;

    localparam logic [7:0] CMD_WRITE = 8'h38;
    localparam logic [7:0] CMD_READ  = 8'hEB;

    localparam int unsigned CMD_NIBBLES  = 2;
    localparam int unsigned ADDR_NIBBLES = 6;
    localparam int unsigned WORD_NIBBLES = 8;

    localparam int unsigned NIB_W  = 4;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned CNT_W  = 3;

endpackage

// File: rtl/qspi_sram_responder_if.sv
// Control/status side of the responder: chip select, status flags and the
// backdoor memory port. The quad data bus stays a plain inout on the top.
interface qspi_sram_responder_if #(
    parameter int unsigned IDX_W = 8
);
    logic              cs_n;
    logic              busy;
    logic              cmd_err;
    logic [IDX_W-1:0]  dbg_addr;
    logic [31:0]       dbg_data;

    modport slave (
        input  cs_n,
        input  dbg_addr,
        output busy,
        output cmd_err,
        output dbg_data
    );

    modport master (
        output cs_n,
        output dbg_addr,
        input  busy,
        input  cmd_err,
        input  dbg_data
    );
endinterface

// File: rtl/qspi_nibble_shifter.sv
// 32-bit nibble shift register with parallel load and a 3-bit nibble counter,
// shared by the command, address and data phases.
module qspi_nibble_shifter
    import qspi_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              ld_en,
    input  logic [WORD_W-1:0] ld_word,
    input  logic              sh_en,
    input  logic              cnt_clr,
    input  logic [NIB_W-1:0]  nib_in,
    output logic [NIB_W-1:0]  nib_out,
    output logic [CNT_W-1:0]  cnt,
    output logic [WORD_W-1:0] shift_word_c
);

    logic [WORD_W-1:0] sr_q, sr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    assign shift_word_c = {sr_q[WORD_W-NIB_W-1:0], nib_in};
    assign nib_out      = sr_q[WORD_W-1 -: NIB_W];
    assign cnt          = cnt_q;

    // Load wins over shift; a clear may accompany a shift or stand alone.
    always_comb begin
        sr_d  = sr_q;
        cnt_d = cnt_q;
        if (ld_en) begin
            sr_d  = ld_word;
            cnt_d = '0;
        end else if (sh_en) begin
            sr_d  = shift_word_c;
            cnt_d = cnt_clr ? '0 : cnt_q + CNT_W'(1);
        end else if (cnt_clr) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sr_q  <= '0;
            cnt_q <= '0;
        end else begin
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/qspi_sram_responder.sv
// QPI SRAM target: decodes quad command/address/dummy phases and serves
// unbounded wrapping read or write bursts from an internal word memory.
module qspi_sram_responder #(
    parameter int unsigned DEPTH        = 256,
    parameter int unsigned DUMMY_CYCLES = 2,
    parameter logic [7:0]  CMD_WRITE    = qspi_pkg::CMD_WRITE,
    parameter logic [7:0]  CMD_READ     = qspi_pkg::CMD_READ
) (
    input  logic                  clk,
    input  logic                  reset,
    inout  wire  [3:0]            sio,
    qspi_sram_responder_if.slave  bus
);
    import qspi_pkg::*;

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned DCNT_W = 4;

    state_e             state_q, state_d;
    logic               is_wr_q, is_wr_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [DCNT_W-1:0]  dcnt_q, dcnt_d;
    logic               oe_q, oe_d;
    logic               cmd_err_q, cmd_err_d;

    logic               sh_en, ld_en, cnt_clr, mem_we;
    logic [NIB_W-1:0]   nib_in, nib_out;
    logic [CNT_W-1:0]   cnt;
    logic [WORD_W-1:0]  shift_word_c, ld_word;
    logic [IDX_W-1:0]   rd_idx, idx_inc;
    logic [7:0]         opcode;

    logic [WORD_W-1:0]  mem [DEPTH];

    qspi_nibble_shifter u_shifter (
        .clk          (clk),
        .reset        (reset),
        .ld_en        (ld_en),
        .ld_word      (ld_word),
        .sh_en        (sh_en),
        .cnt_clr      (cnt_clr),
        .nib_in       (nib_in),
        .nib_out      (nib_out),
        .cnt          (cnt),
        .shift_word_c (shift_word_c)
    );

    assign idx_inc = idx_q + IDX_W'(1);
    assign opcode  = shift_word_c[7:0];
    assign ld_word = mem[rd_idx];
    // Our own read data is not fed back into the shifter.
    assign nib_in  = (state_q == RDATA) ? '0 : sio;

    always_comb begin
        state_d   = state_q;
        is_wr_d   = is_wr_q;
        idx_d     = idx_q;
        dcnt_d    = dcnt_q;
        oe_d      = oe_q;
        cmd_err_d = 1'b0;
        sh_en     = 1'b0;
        ld_en     = 1'b0;
        cnt_clr   = 1'b0;
        mem_we    = 1'b0;
        rd_idx    = idx_q;

        if (bus.cs_n) begin
            state_d = IDLE;
            oe_d    = 1'b0;
            cnt_clr = 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    sh_en   = 1'b1;
                    state_d = CMD;
                end
                CMD: begin
                    sh_en = 1'b1;
                    if (cnt == CNT_W'(CMD_NIBBLES - 1)) begin
                        cnt_clr = 1'b1;
                        if (opcode == CMD_WRITE) begin
                            is_wr_d = 1'b1;
                            state_d = ADDR;
                        end else if (opcode == CMD_READ) begin
                            is_wr_d = 1'b0;
                            state_d = ADDR;
                        end else begin
                            cmd_err_d = 1'b1;
                            state_d   = DISCARD;
                        end
                    end
                end
                ADDR: begin
                    sh_en = 1'b1;
                    if (cnt == CNT_W'(ADDR_NIBBLES - 1)) begin
                        cnt_clr = 1'b1;
                        idx_d   = shift_word_c[IDX_W-1:0];
                        dcnt_d  = '0;
                        state_d = is_wr_q ? WDATA : DUMMY;
                    end
                end
                DUMMY: begin
                    if (dcnt_q == DCNT_W'(DUMMY_CYCLES - 1)) begin
                        ld_en   = 1'b1;
                        oe_d    = 1'b1;
                        state_d = RDATA;
                    end else begin
                        dcnt_d = dcnt_q + DCNT_W'(1);
                    end
                end
                RDATA: begin
                    // Next word is loaded on the last nibble so the burst has no gap.
                    if (cnt == CNT_W'(WORD_NIBBLES - 1)) begin
                        idx_d  = idx_inc;
                        rd_idx = idx_inc;
                        ld_en  = 1'b1;
                    end else begin
                        sh_en = 1'b1;
                    end
                end
                WDATA: begin
                    sh_en = 1'b1;
                    if (cnt == CNT_W'(WORD_NIBBLES - 1)) begin
                        mem_we = 1'b1;
                        idx_d  = idx_inc;
                    end
                end
                DISCARD: begin
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            is_wr_q   <= 1'b0;
            idx_q     <= '0;
            dcnt_q    <= '0;
            oe_q      <= 1'b0;
            cmd_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            is_wr_q   <= is_wr_d;
            idx_q     <= idx_d;
            dcnt_q    <= dcnt_d;
            oe_q      <= oe_d;
            cmd_err_q <= cmd_err_d;
        end
    end

    // Contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[idx_q] <= shift_word_c;
        end
    end

    assign sio          = oe_q ? nib_out : 4'bzzzz;
    assign bus.busy     = (state_q != IDLE);
    assign bus.cmd_err  = cmd_err_q;
    assign bus.dbg_data = mem[bus.dbg_addr];

endmodule

// File: tb/tb_qspi_sram_responder.sv
// Directed bench for qspi_sram_responder: quad write/read transactions,
// burst wrap, partial write, bad opcode and reset mid-read.
module tb_qspi_sram_responder;

    localparam int unsigned DEPTH = 256;
    localparam int unsigned IDX_W = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       tb_oe;
    logic [3:0] tb_nib;
    wire  [3:0] sio;
    wire        sio_is_z;

    int n_tests = 0;
    int n_fail  = 0;

    assign sio      = tb_oe ? tb_nib : 4'bzzzz;
    assign sio_is_z = (sio === 4'bzzzz);

    qspi_sram_responder_if #(.IDX_W(IDX_W)) bus ();

    qspi_sram_responder #(
        .DEPTH        (DEPTH),
        .DUMMY_CYCLES (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .sio   (sio),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One bus cycle: drive at negedge, return just after the consuming posedge.
    task automatic bus_cyc(input logic cs, input logic [3:0] nib, input logic drv);
        @(negedge clk);
        bus.cs_n = cs;
        tb_nib   = nib;
        tb_oe    = drv;
        @(posedge clk);
        #1;
    endtask

    // One read cycle: sample what the responder presents before the posedge.
    task automatic rd_cyc(output logic [3:0] nib, output logic z);
        @(negedge clk);
        bus.cs_n = 1'b0;
        tb_oe    = 1'b0;
        #1;
        nib = sio;
        z   = sio_is_z;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] val, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            bus_cyc(1'b0, val[4*i +: 4], 1'b1);
        end
    endtask

    task automatic read_word(output logic [31:0] w);
        logic [3:0] nib;
        logic       z;
        w = '0;
        for (int i = 0; i < 8; i++) begin
            rd_cyc(nib, z);
            w = {w[27:0], nib};
        end
    endtask

    task automatic peek(input logic [7:0] a, input logic [31:0] exp, input string tag);
        bus.dbg_addr = a;
        #1;
        check(tag, bus.dbg_data, exp);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        logic [3:0]  nib;
        logic        z;
        logic [31:0] w;
        logic [3:0]  exp_rd [8];

        exp_rd = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h6, 4'h4};
        reset        = 1'b1;
        bus.cs_n     = 1'b1;
        bus.dbg_addr = '0;
        tb_oe        = 1'b0;
        tb_nib       = '0;

        bus_cyc(1'b1, 4'h0, 1'b0);
        bus_cyc(1'b1, 4'h0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        repeat (5) bus_cyc(1'b1, 4'h0, 1'b0);
        check("idle_sio_z", 32'(sio_is_z), 32'd1);
        check("idle_busy", 32'(bus.busy), 32'd0);
        check("idle_cmd_err", 32'(bus.cmd_err), 32'd0);

        // Seed a location the partial-write test must leave alone.
        send(32'h38, 2); send(32'h00004D, 6); send(32'hA5A5A5A5, 8);
        bus_cyc(1'b1, 4'h0, 1'b0);
        peek(8'h4D, 32'hA5A5A5A5, "seed_4d");

        send(32'h38, 2);
        check("wr_busy", 32'(bus.busy), 32'd1);
        send(32'h00006F, 6); send(32'h00000064, 8);
        bus_cyc(1'b1, 4'h0, 1'b0);
        check("wr_busy_drop", 32'(bus.busy), 32'd0);
        peek(8'h6F, 32'h00000064, "wr_6f");

        send(32'hEB, 2); send(32'h00006F, 6);
        for (int i = 0; i < 2; i++) begin
            rd_cyc(nib, z);
            check($sformatf("dummy_z%0d", i), 32'(z), 32'd1);
        end
        for (int i = 0; i < 8; i++) begin
            rd_cyc(nib, z);
            check($sformatf("rd_nib%0d", i), 32'(nib), 32'(exp_rd[i]));
        end
        bus_cyc(1'b1, 4'h0, 1'b0);
        check("rd_end_sio_z", 32'(sio_is_z), 32'd1);
        check("rd_end_busy", 32'(bus.busy), 32'd0);

        // Back-to-back after a single cs_n-high cycle, crossing the top word.
        send(32'h38, 2); send(32'h0000FF, 6);
        send(32'h11111111, 8); send(32'h22222222, 8);
        bus_cyc(1'b1, 4'h0, 1'b0);
        peek(8'hFF, 32'h11111111, "wrap_ff");
        peek(8'h00, 32'h22222222, "wrap_00");

        send(32'hEB, 2); send(32'h0000FF, 6);
        rd_cyc(nib, z); rd_cyc(nib, z);
        read_word(w);
        check("rd_wrap_w0", w, 32'h11111111);
        read_word(w);
        check("rd_wrap_w1", w, 32'h22222222);
        bus_cyc(1'b1, 4'h0, 1'b0);

        send(32'h38, 2); send(32'h00014D, 6); send(32'h000FFFFF, 5);
        bus_cyc(1'b1, 4'h0, 1'b0);
        check("partial_busy", 32'(bus.busy), 32'd0);
        peek(8'h4D, 32'hA5A5A5A5, "partial_4d");

        send(32'h9F, 2);
        check("bad_cmd_err", 32'(bus.cmd_err), 32'd1);
        bus_cyc(1'b0, 4'h0, 1'b0);
        check("bad_cmd_err_off", 32'(bus.cmd_err), 32'd0);
        check("bad_busy", 32'(bus.busy), 32'd1);
        check("bad_sio_z", 32'(sio_is_z), 32'd1);
        send(32'h00006F, 6); send(32'hDEADBEEF, 8);
        check("bad_cmd_err_later", 32'(bus.cmd_err), 32'd0);
        bus_cyc(1'b1, 4'h0, 1'b0);
        peek(8'h6F, 32'h00000064, "bad_6f");
        peek(8'h00, 32'h22222222, "bad_00");

        send(32'hEB, 2); send(32'h00006F, 6);
        rd_cyc(nib, z); rd_cyc(nib, z);
        for (int i = 0; i < 3; i++) rd_cyc(nib, z);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("rst_mid_sio_z", 32'(sio_is_z), 32'd1);
        check("rst_mid_busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        reset    = 1'b0;
        bus.cs_n = 1'b1;
        bus_cyc(1'b1, 4'h0, 1'b0);
        peek(8'h6F, 32'h00000064, "intact_6f");
        peek(8'hFF, 32'h11111111, "intact_ff");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
